// File: rtl/fwd_pkg.sv
// Shared constants for the operand forwarding controller.
// Optional counters are built only when FWD_STATS_EN is defined.
package fwd_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_RF    = 2'd0;
  localparam sel_t SEL_EXMEM = 2'd1;
  localparam sel_t SEL_MEMWB = 2'd2;

  localparam int CNT_W = 16;

endpackage

// File: rtl/fwd_ctrl_if.sv
// EX/ID-side bundle of the forwarding controller.
// master drives pipeline info; slave is the controller.
interface fwd_ctrl_if
  import fwd_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 6
);

  logic              ex_valid;
  logic              ex_wr_en;
  logic              ex_is_load;
  logic [REG_AW-1:0] ex_rd;
  logic [DATA_W-1:0] ex_result;
  logic [DATA_W-1:0] mem_rdata;
  logic [REG_AW-1:0] id_rs_a;
  logic [REG_AW-1:0] id_rs_b;

  sel_t              sel_a;
  sel_t              sel_b;
  logic [DATA_W-1:0] exmem_data;
  logic [DATA_W-1:0] memwb_data;
  logic              hazard_stall;
  logic [CNT_W-1:0]  fwd_count;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output ex_valid, ex_wr_en, ex_is_load,
    output ex_rd, ex_result, mem_rdata,
    output id_rs_a, id_rs_b,
    input  sel_a, sel_b,
    input  exmem_data, memwb_data,
    input  hazard_stall,
    input  fwd_count, stall_count
  );

  modport slave (
    input  ex_valid, ex_wr_en, ex_is_load,
    input  ex_rd, ex_result, mem_rdata,
    input  id_rs_a, id_rs_b,
    output sel_a, sel_b,
    output exmem_data, memwb_data,
    output hazard_stall,
    output fwd_count, stall_count
  );

endinterface

// File: rtl/fwd_slot.sv
// One pipeline result slot: valid/rd/data with freeze
// and bubble insertion.
module fwd_slot #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              bubble,
  input  logic              valid_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_q,
  output logic [REG_AW-1:0] rd_q,
  output logic [DATA_W-1:0] data_q
);

  logic              valid_d;
  logic [REG_AW-1:0] rd_d;
  logic [DATA_W-1:0] data_d;

  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    data_d  = data_q;
    if (!hold) begin
      valid_d = valid_i & ~bubble;
      rd_d    = rd_i;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/fwd_ctrl.sv
// Operand forwarding and load-use hazard controller.
// Define FWD_STATS_EN to build the fwd/stall event counters.
module fwd_ctrl
  import fwd_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 6
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     hold,
  input  logic     flush,
  fwd_ctrl_if.slave bus
);

  logic              v1, v2;
  logic [REG_AW-1:0] rd1, rd2;
  logic [DATA_W-1:0] data1, data2;
  logic [DATA_W-1:0] wb_data;
  logic              ld1_q, ld1_d;
  logic              stall;
  logic              bubble1;
  logic              m1a, m1b, m2a, m2b;
  sel_t              sel_a, sel_b;

  assign bubble1 = flush | stall;
  assign wb_data = ld1_q ? bus.mem_rdata : data1;

  fwd_slot #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_exmem (
    .clk     (clk),
    .rst_n   (rst_n),
    .hold    (hold),
    .bubble  (bubble1),
    .valid_i (bus.ex_valid & bus.ex_wr_en),
    .rd_i    (bus.ex_rd),
    .data_i  (bus.ex_result),
    .valid_q (v1),
    .rd_q    (rd1),
    .data_q  (data1)
  );

  fwd_slot #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_memwb (
    .clk     (clk),
    .rst_n   (rst_n),
    .hold    (hold),
    .bubble  (1'b0),
    .valid_i (v1),
    .rd_i    (rd1),
    .data_i  (wb_data),
    .valid_q (v2),
    .rd_q    (rd2),
    .data_q  (data2)
  );

  always_comb begin
    ld1_d = ld1_q;
    if (!hold) ld1_d = bus.ex_is_load;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ld1_q <= 1'b0;
    else        ld1_q <= ld1_d;
  end

  // r0 is hardwired zero and never a forwarding source
  assign m1a = v1 && (rd1 != '0) && (rd1 == bus.id_rs_a);
  assign m1b = v1 && (rd1 != '0) && (rd1 == bus.id_rs_b);
  assign m2a = v2 && (rd2 != '0) && (rd2 == bus.id_rs_a);
  assign m2b = v2 && (rd2 != '0) && (rd2 == bus.id_rs_b);

  assign stall = ld1_q & (m1a | m1b);

  // a pending load in EX/MEM hides older MEM/WB copies
  always_comb begin
    sel_a = SEL_RF;
    priority case (1'b1)
      m1a:     sel_a = ld1_q ? SEL_RF : SEL_EXMEM;
      m2a:     sel_a = SEL_MEMWB;
      default: sel_a = SEL_RF;
    endcase
  end

  always_comb begin
    sel_b = SEL_RF;
    priority case (1'b1)
      m1b:     sel_b = ld1_q ? SEL_RF : SEL_EXMEM;
      m2b:     sel_b = SEL_MEMWB;
      default: sel_b = SEL_RF;
    endcase
  end

  assign bus.sel_a        = sel_a;
  assign bus.sel_b        = sel_b;
  assign bus.hazard_stall = stall;
  assign bus.exmem_data   = data1;
  assign bus.memwb_data   = data2;

`ifdef FWD_STATS_EN
  logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             any_fwd;

  assign any_fwd = (sel_a != SEL_RF) || (sel_b != SEL_RF);

  always_comb begin
    fwd_cnt_d   = fwd_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (!hold) begin
      if (any_fwd && (fwd_cnt_q != '1))
        fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
      if (stall && (stall_cnt_q != '1))
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      fwd_cnt_q   <= fwd_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.fwd_count   = fwd_cnt_q;
  assign bus.stall_count = stall_cnt_q;
`else
  assign bus.fwd_count   = '0;
  assign bus.stall_count = '0;
`endif

endmodule
